// File: rtl/game_pkg.sv
// Shared types and helpers for the sprite motion sequencer.
package game_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Sign-extend a w-bit two's complement speed (held in the low bits of d) to 32 bits.
  function automatic logic signed [31:0] sext_speed(input logic [31:0] d, input int w);
    logic signed [31:0] t;
    t = signed'(d << (32 - w));
    return t >>> (32 - w);
  endfunction

  // Negate a w-bit speed; the most-negative value maps to the most-positive
  // so a bounce never flips back to the same sign.
  function automatic logic signed [31:0] sat_neg(input logic [31:0] d, input int w);
    logic signed [31:0] v;
    logic signed [31:0] mn;
    v  = sext_speed(d, w);
    mn = -(32'sd1 <<< (w - 1));
    if (v == mn) return -v - 32'sd1;
    return -v;
  endfunction

endpackage

// File: rtl/game_sprite_control_if.sv
// Command/status bundle between a game controller and one sprite sequencer.
interface game_sprite_control_if #(
  parameter int X_WIDTH  = 10,
  parameter int Y_WIDTH  = 10,
  parameter int DX_WIDTH = 2,
  parameter int DY_WIDTH = 2
);
  logic                launch;
  logic                stop;
  logic                strobe;
  logic [X_WIDTH-1:0]  start_x;
  logic [Y_WIDTH-1:0]  start_y;
  logic [DX_WIDTH-1:0] start_dx;
  logic [DY_WIDTH-1:0] start_dy;
  logic                sprite_we;
  logic [X_WIDTH-1:0]  sprite_x;
  logic [Y_WIDTH-1:0]  sprite_y;
  logic [DX_WIDTH-1:0] sprite_dx;
  logic [DY_WIDTH-1:0] sprite_dy;
  logic                running;
  logic                done;

  modport master (
    output launch, stop, strobe, start_x, start_y, start_dx, start_dy,
    input  sprite_we, sprite_x, sprite_y, sprite_dx, sprite_dy, running, done
  );

  modport slave (
    input  launch, stop, strobe, start_x, start_y, start_dx, start_dy,
    output sprite_we, sprite_x, sprite_y, sprite_dx, sprite_dy, running, done
  );
endinterface

// File: rtl/game_sprite_axis_step.sv
// One axis of a motion step: next position, bounce speed and edge detection.
// Purely combinational; the caller decides whether to bounce or retire.
module game_sprite_axis_step
  import game_pkg::*;
#(
  parameter int PW    = 10,
  parameter int DW    = 2,
  parameter int LIMIT = 632
) (
  input  logic [PW-1:0] pos,
  input  logic [DW-1:0] d,
  output logic [PW-1:0] next_pos,
  output logic [DW-1:0] next_d,
  output logic          out_of_range
);
  logic signed [PW:0] sum;

  // Step in PW+1 signed bits so both underflow below 0 and overflow past LIMIT are visible.
  always_comb begin
    sum          = $signed({1'b0, pos}) + $signed((PW+1)'(sext_speed(32'(d), DW)));
    out_of_range = sum[PW] || (sum > $signed((PW+1)'(LIMIT)));
    if (out_of_range) begin
      next_pos = pos;
      next_d   = DW'(sat_neg(32'(d), DW));
    end else begin
      next_pos = sum[PW-1:0];
      next_d   = d;
    end
  end
endmodule

// File: rtl/game_sprite_control.sv
// Per-sprite motion sequencer: launch, periodic stepping on frame strobes,
// edge bounce or retirement. Build option GAME_SPRITE_BOUNCE_EN selects
// bounce at screen edges; without it the sprite retires at an edge.
//
// state   | meaning
// IDLE    | no motion, outputs hold last written values
// RUN     | counting frame strobes, stepping every STEP_FRAMES strobes
module game_sprite_control
  import game_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int SPRITE_WIDTH  = 8,
  parameter int SPRITE_HEIGHT = 8,
  parameter int X_WIDTH       = 10,
  parameter int Y_WIDTH       = 10,
  parameter int DX_WIDTH      = 2,
  parameter int DY_WIDTH      = 2,
  parameter int STEP_FRAMES   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  game_sprite_control_if.slave  bus
);
  localparam int X_LIMIT = SCREEN_WIDTH - SPRITE_WIDTH;
  localparam int Y_LIMIT = SCREEN_HEIGHT - SPRITE_HEIGHT;
  localparam int CNT_W   = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_FRAMES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [X_WIDTH-1:0]  x_q, x_d, nx;
  logic [Y_WIDTH-1:0]  y_q, y_d, ny;
  logic [DX_WIDTH-1:0] dx_q, dx_d, ndx;
  logic [DY_WIDTH-1:0] dy_q, dy_d, ndy;
  logic                we_q, we_d;
  logic                done_q, done_d;
  logic                oor_x, oor_y;

  game_sprite_axis_step #(.PW(X_WIDTH), .DW(DX_WIDTH), .LIMIT(X_LIMIT)) u_step_x (
    .pos(x_q), .d(dx_q), .next_pos(nx), .next_d(ndx), .out_of_range(oor_x)
  );

  game_sprite_axis_step #(.PW(Y_WIDTH), .DW(DY_WIDTH), .LIMIT(Y_LIMIT)) u_step_y (
    .pos(y_q), .d(dy_q), .next_pos(ny), .next_d(ndy), .out_of_range(oor_y)
  );

  // Next-state logic; stop outranks launch, launch outranks strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    if (bus.stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (bus.launch) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      x_d     = bus.start_x;
      y_d     = bus.start_y;
      dx_d    = bus.start_dx;
      dy_d    = bus.start_dy;
      we_d    = 1'b1;
    end else if (state_q == ST_RUN && bus.strobe) begin
      if (cnt_q != CNT_LAST) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = '0;
`ifdef GAME_SPRITE_BOUNCE_EN
        x_d  = nx;
        y_d  = ny;
        dx_d = ndx;
        dy_d = ndy;
        we_d = 1'b1;
`else
        if (oor_x || oor_y) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          x_d  = nx;
          y_d  = ny;
          we_d = 1'b1;
        end
`endif
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  assign bus.sprite_we = we_q;
  assign bus.sprite_x  = x_q;
  assign bus.sprite_y  = y_q;
  assign bus.sprite_dx = dx_q;
  assign bus.sprite_dy = dy_q;
  assign bus.running   = (state_q == ST_RUN);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_game_sprite_control.sv
// Bench for game_sprite_control with STEP_FRAMES=2; expectations for both
// the bounce and retire builds are selected by GAME_SPRITE_BOUNCE_EN.
module tb_game_sprite_control;

  typedef struct {
    string nm;
    int    launch, stop, strobe;
    int    sx, sy, sdx, sdy;
    int    we, x, y, dx, dy, run, done;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs[$];
  vec_t sb[$];

  game_sprite_control_if #(.X_WIDTH(10), .Y_WIDTH(10), .DX_WIDTH(2), .DY_WIDTH(2)) bus ();

  game_sprite_control #(.STEP_FRAMES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string nm, int l, int s, int st, int sx, int sy, int sdx, int sdy,
                              int we, int x, int y, int dx, int dy, int run, int done);
    vec_t v;
    v.nm = nm; v.launch = l; v.stop = s; v.strobe = st;
    v.sx = sx; v.sy = sy; v.sdx = sdx; v.sdy = sdy;
    v.we = we; v.x = x; v.y = y; v.dx = dx; v.dy = dy; v.run = run; v.done = done;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_outputs(input vec_t e);
    chk({e.nm, ".we"},   int'(bus.sprite_we), e.we);
    chk({e.nm, ".x"},    int'(bus.sprite_x),  e.x);
    chk({e.nm, ".y"},    int'(bus.sprite_y),  e.y);
    chk({e.nm, ".dx"},   int'(bus.sprite_dx), e.dx);
    chk({e.nm, ".dy"},   int'(bus.sprite_dy), e.dy);
    chk({e.nm, ".run"},  int'(bus.running),   e.run);
    chk({e.nm, ".done"}, int'(bus.done),      e.done);
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic apply(input vec_t v);
    vec_t e;
    bus.launch   = v.launch[0];
    bus.stop     = v.stop[0];
    bus.strobe   = v.strobe[0];
    bus.start_x  = v.sx[9:0];
    bus.start_y  = v.sy[9:0];
    bus.start_dx = v.sdx[1:0];
    bus.start_dy = v.sdy[1:0];
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_outputs(e);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.launch = 1'b0; bus.stop = 1'b0; bus.strobe = 1'b0;
    bus.start_x = '0; bus.start_y = '0; bus.start_dx = '0; bus.start_dy = '0;

    // speeds as raw 2-bit codes: 1=+1, 3=-1, 2=-2
    vecs.push_back(mk("launch",      1,0,0, 100,50,1,3,  1,100,50,1,3,1,0));
    vecs.push_back(mk("idle_run",    0,0,0, 0,0,0,0,     0,100,50,1,3,1,0));
    vecs.push_back(mk("strobe1",     0,0,1, 0,0,0,0,     0,100,50,1,3,1,0));
    vecs.push_back(mk("strobe2",     0,0,1, 0,0,0,0,     1,101,49,1,3,1,0));
    vecs.push_back(mk("strobe3",     0,0,1, 0,0,0,0,     0,101,49,1,3,1,0));
    vecs.push_back(mk("strobe4",     0,0,1, 0,0,0,0,     1,102,48,1,3,1,0));
    vecs.push_back(mk("stop_all",    1,1,1, 7,7,1,1,     0,102,48,1,3,0,0));
    vecs.push_back(mk("idle_strobe", 0,0,1, 0,0,0,0,     0,102,48,1,3,0,0));
    vecs.push_back(mk("launch_y1",   1,0,0, 5,1,0,3,     1,5,1,0,3,1,0));
    vecs.push_back(mk("y1_s1",       0,0,1, 0,0,0,0,     0,5,1,0,3,1,0));
    vecs.push_back(mk("y_to_0",      0,0,1, 0,0,0,0,     1,5,0,0,3,1,0));
    vecs.push_back(mk("cnt_to_1",    0,0,1, 0,0,0,0,     0,5,0,0,3,1,0));
    vecs.push_back(mk("relaunch",    1,0,1, 200,100,3,1, 1,200,100,3,1,1,0));
    vecs.push_back(mk("cnt_clr",     0,0,1, 0,0,0,0,     0,200,100,3,1,1,0));
    vecs.push_back(mk("relaunch_st", 0,0,1, 0,0,0,0,     1,199,101,3,1,1,0));
    vecs.push_back(mk("launch_y0",   1,0,0, 10,0,0,3,    1,10,0,0,3,1,0));
    vecs.push_back(mk("y0_s1",       0,0,1, 0,0,0,0,     0,10,0,0,3,1,0));
`ifdef GAME_SPRITE_BOUNCE_EN
    vecs.push_back(mk("y0_edge",     0,0,1, 0,0,0,0,     1,10,0,0,1,1,0));
    vecs.push_back(mk("y0_after",    0,0,0, 0,0,0,0,     0,10,0,0,1,1,0));
`else
    vecs.push_back(mk("y0_edge",     0,0,1, 0,0,0,0,     0,10,0,0,3,0,1));
    vecs.push_back(mk("y0_after",    0,0,0, 0,0,0,0,     0,10,0,0,3,0,0));
`endif
    vecs.push_back(mk("launch_x632", 1,0,0, 632,20,1,0,  1,632,20,1,0,1,0));
    vecs.push_back(mk("x632_s1",     0,0,1, 0,0,0,0,     0,632,20,1,0,1,0));
`ifdef GAME_SPRITE_BOUNCE_EN
    vecs.push_back(mk("x632_edge",   0,0,1, 0,0,0,0,     1,632,20,3,0,1,0));
    vecs.push_back(mk("x632_stop",   0,1,0, 0,0,0,0,     0,632,20,3,0,0,0));
`else
    vecs.push_back(mk("x632_edge",   0,0,1, 0,0,0,0,     0,632,20,1,0,0,1));
    vecs.push_back(mk("x632_stop",   0,1,0, 0,0,0,0,     0,632,20,1,0,0,0));
`endif
    vecs.push_back(mk("launch_x0",   1,0,0, 0,30,2,0,    1,0,30,2,0,1,0));
    vecs.push_back(mk("x0_s1",       0,0,1, 0,0,0,0,     0,0,30,2,0,1,0));
`ifdef GAME_SPRITE_BOUNCE_EN
    vecs.push_back(mk("x0_edge",     0,0,1, 0,0,0,0,     1,0,30,1,0,1,0));
`else
    vecs.push_back(mk("x0_edge",     0,0,1, 0,0,0,0,     0,0,30,2,0,0,1));
`endif

    // Reset values are visible while reset is held, before any clock edge.
    #1;
    chk_outputs(mk("reset", 0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
    #11;
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Asynchronous reset in the middle of RUN, between strobes.
    apply(mk("pre_rst_launch", 1,0,0, 100,50,1,3, 1,100,50,1,3,1,0));
    apply(mk("pre_rst_strobe", 0,0,1, 0,0,0,0,    0,100,50,1,3,1,0));
    bus.strobe = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk_outputs(mk("async_rst", 0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply(mk("post_rst_s1", 0,0,1, 0,0,0,0, 0,0,0,0,0,0,0));
    apply(mk("post_rst_s2", 0,0,1, 0,0,0,0, 0,0,0,0,0,0,0));
    bus.strobe = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
